servo_pwm_frame: RTL and testbench
==================================

# servo_pwm_frame

Frame-synchronous hobby-servo PWM driver for the hexapod leg channels. Sits directly downstream of the ROM position sequencer and consumes its 8-bit position word. Each 20 ms frame produces one pulse of 0.5–2.5 ms. Position and enable are latched only at frame boundaries, so mid-frame sequencer updates never produce runt or stretched pulses; an optional slew limiter smooths gait-table jumps.

## Interface
- `FRAME_CYC`, 240000: clock cycles per PWM frame (20 ms at 12 MHz).
- `MIN_CYC`, 6000: pulse width for pos = 0 (0.5 ms).
- `STEP_CYC`, 94: extra cycles per position LSB; pos = 255 gives 29970 cycles.
- `CW`, 18: width of the frame counter and width registers. Must hold FRAME_CYC-1.
- `SLEW_STEP`, 4: maximum change of the applied position per frame. Used only with the slew feature.
- Parameter constraint: MIN_CYC + 255*STEP_CYC < FRAME_CYC.

Ports:
- `clk`, in, 1: system clock, 12 MHz.
- `rstn`, in, 1: asynchronous, active-low reset.
- `pos`, in, 8: target position from the sequencer. Sampled only at frame end.
- `ena`, in, 1: output enable. Sampled only at frame end.
- `servo`, out, 1: PWM output to the servo signal pin. Registered.
- `frame_tick`, out, 1: one-cycle pulse in the first cycle of every frame.
- `pos_applied`, out, 8: position actually used for the current frame.

## Operation
- Frame counter `cnt` counts 0 … FRAME_CYC-1, then wraps to 0. It runs continuously, regardless of `ena`.
- Latch event: the cycle in which `cnt == FRAME_CYC-1`. On that clock edge:
  - `pos_applied` takes its new value (see Configuration).
  - `width` is set to MIN_CYC + new_pos_applied*STEP_CYC. The product is computed at CW bits with no truncation.
  - `ena_lat` is set to `ena`.
- `servo` is high in cycles where `ena_lat == 1` and `cnt < width`; otherwise low. Pulse length is exactly `width` cycles, starting at `cnt == 0`.
- `frame_tick` is high exactly in cycles where `cnt == 0`.
- `pos` and `ena` changes at any time other than the latch event have no effect until the next latch event.
- If `pos` changes in the same cycle as the latch event, the value present in that cycle is captured.
- Async reset (`rstn` low) sets:
  - `cnt` = 0
  - `pos_applied` = 8'd128
  - `width` = MIN_CYC + 128*STEP_CYC
  - `ena_lat` = 0
  - `servo` = 0
  - `frame_tick` = 0
- Reset mid-pulse forces `servo` low immediately, with no waiting for a clock edge.
- After release, the first frame starts at `cnt == 0`. It is silent (`ena_lat == 0`), but `frame_tick` still fires.

## Timing
- `cnt` is 0 in the first rising edge after `rstn` deasserts.
- `frame_tick` is high in the first cycle after reset release, then every FRAME_CYC cycles.
- Input-to-output latency: a `pos`/`ena` value captured at the latch event controls the frame that starts on the next cycle. Worst case is FRAME_CYC cycles from an input change to its effect.
- `servo` rises in the same cycle that `frame_tick` is high (both are decoded from `cnt == 0`, registered). It falls after exactly `width` cycles.
- There is no handshake; the sequencer may change `pos` at any rate.

## Configuration
- Macro: `SERVO_SLEW_EN`.
- Defined:
  - At each latch event, `pos_applied` moves toward `pos` by min(SLEW_STEP, |pos - pos_applied|).
  - If `pos == pos_applied`, it is unchanged.
  - Arithmetic is done at 9 bits to avoid wrap, so the result is always within 0–255.
- Undefined: `pos_applied` is set to `pos` directly at each latch event; SLEW_STEP is unused.

## Test plan
- **Reset:** assert `rstn` = 0 mid-frame while `servo` is high. Required: `servo`, `frame_tick` = 0 asynchronously and `pos_applied` = 128. After release, the first frame has no pulse and `frame_tick` is at cycle 0.
- **Extremes:** `ena` = 1, `pos` = 0 held. Required: pulse width is 6000 cycles. With `pos` = 255: 29970 cycles. Period is 240000 cycles between rising edges.
- **Mid-frame change:** `pos` goes 0→255 at cnt = 3000 of a pos = 0 frame. Required: the current pulse is still 6000 cycles and the next pulse is 29970 cycles (slew off).
- **Enable gating:** `ena` = 0 at the latch event. Required: `servo` stays low the whole next frame while `frame_tick` still pulses. Re-enabling restores the pulse one frame later.
- **Slew (`SERVO_SLEW_EN` defined):** `pos_applied` = 128, `pos` = 140. Required: successive frames apply 132, 136, 140, 140. Then `pos` = 0 from 140 applies 136, 132, …, with no underflow at 0.
- **Latch-edge capture:** change `pos` exactly in the `cnt == FRAME_CYC-1` cycle. Required: the new value is applied to the immediately following frame.

Source files
------------

// File: rtl/servo_pwm_frame.sv
// servo_pwm_frame: frame-synchronous hobby-servo PWM driver.
// Position and enable are captured only at the frame boundary, so each frame
// always carries one complete pulse of MIN_CYC + pos*STEP_CYC cycles.
// Optional feature macro: SERVO_SLEW_EN. When it is defined, the applied
// position moves toward the target by at most SLEW_STEP per frame.
module servo_pwm_frame #(
  parameter int unsigned FRAME_CYC = 240000,
  parameter int unsigned MIN_CYC   = 6000,
  parameter int unsigned STEP_CYC  = 94,
  parameter int unsigned CW        = 18,
  parameter int unsigned SLEW_STEP = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] pos,
  input  logic       ena,
  output logic       servo,
  output logic       frame_tick,
  output logic [7:0] pos_applied
);

  localparam logic [CW-1:0] LP_LAST      = CW'(FRAME_CYC - 1);
  localparam logic [CW-1:0] LP_MIN       = CW'(MIN_CYC);
  localparam logic [CW-1:0] LP_STEP      = CW'(STEP_CYC);
  localparam logic [7:0]    LP_POS_RST   = 8'd128;
  localparam logic [CW-1:0] LP_WIDTH_RST = CW'(MIN_CYC + 128 * STEP_CYC);

  // Reject parameter sets where the longest pulse does not fit in a frame
  if ((MIN_CYC + 255 * STEP_CYC >= FRAME_CYC) || (SLEW_STEP == 0) ||
      (FRAME_CYC > (32'd1 << CW))) begin : g_bad_param
    $error("servo_pwm_frame: illegal parameter set");
  end

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_width;
  logic          r_ena_lat;
  logic [7:0]    r_pos_applied;
  logic          r_servo;
  logic          r_frame_tick;

  logic          w_latch;
  logic [7:0]    w_pos_next;
  logic [CW-1:0] w_width_next;

  assign w_latch = (r_cnt == LP_LAST);

`ifdef SERVO_SLEW_EN
  localparam logic [8:0] LP_SLEW = 9'(SLEW_STEP);
  logic [8:0] w_up;
  logic [8:0] w_dn;

  // Step the applied position toward the target, limited to LP_SLEW per frame
  always_comb begin
    w_pos_next = r_pos_applied;
    w_up       = {1'b0, pos} - {1'b0, r_pos_applied};
    w_dn       = {1'b0, r_pos_applied} - {1'b0, pos};
    if (pos > r_pos_applied) begin
      w_pos_next = (w_up > LP_SLEW) ? 8'({1'b0, r_pos_applied} + LP_SLEW) : pos;
    end else if (pos < r_pos_applied) begin
      w_pos_next = (w_dn > LP_SLEW) ? 8'({1'b0, r_pos_applied} - LP_SLEW) : pos;
    end
  end
`else
  // Without slew limiting the target is applied directly
  assign w_pos_next = pos;
`endif

  assign w_width_next = LP_MIN + (CW'(w_pos_next) * LP_STEP);

  // Free-running frame counter, independent of enable
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_latch) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Capture position, pulse width and enable once per frame at the last count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pos_applied <= LP_POS_RST;
      r_width       <= LP_WIDTH_RST;
      r_ena_lat     <= 1'b0;
    end else if (w_latch) begin
      r_pos_applied <= w_pos_next;
      r_width       <= w_width_next;
      r_ena_lat     <= ena;
    end
  end

  // Registered pulse and frame-start decode from the current count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_servo      <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_servo      <= r_ena_lat && (r_cnt < r_width);
      r_frame_tick <= (r_cnt == '0);
    end
  end

  assign servo       = r_servo;
  assign frame_tick  = r_frame_tick;
  assign pos_applied = r_pos_applied;

endmodule

// File: tb/tb_servo_pwm_frame.sv
// Bench for servo_pwm_frame with a shortened frame (1000 cycles) so the run
// stays short. A time-indexed model predicts every output each cycle; directed
// frames pin pulse widths, gating, latch-edge capture and reset behaviour.
module tb_servo_pwm_frame;

  localparam int unsigned F  = 1000;
  localparam int unsigned MN = 50;
  localparam int unsigned ST = 3;
  localparam int unsigned CB = 10;
  localparam int unsigned SL = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] pos = 8'd0;
  logic       servo;
  logic       frame_tick;
  logic [7:0] pos_applied;

  int n_assert = 0;
  int n_fail   = 0;

  servo_pwm_frame #(
    .FRAME_CYC(F), .MIN_CYC(MN), .STEP_CYC(ST), .CW(CB), .SLEW_STEP(SL)
  ) dut (
    .clk(clk), .rstn(rstn), .pos(pos), .ena(ena),
    .servo(servo), .frame_tick(frame_tick), .pos_applied(pos_applied)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Target-tracking rule for the applied position
  function automatic int next_pa(input int tgt, input int cur);
`ifdef SERVO_SLEW_EN
    if (tgt > cur) return (tgt - cur > SL) ? cur + SL : tgt;
    if (tgt < cur) return (cur - tgt > SL) ? cur - SL : tgt;
    return cur;
`else
    return tgt + 0 * cur;
`endif
  endfunction

  // Model: time since reset release decides frame phase; frame values come
  // from inputs seen at the last cycle of the previous frame.
  int m_n, m_pa, m_ena, m_w, m_ph;
  bit exp_servo, exp_tick;
  bit chk_en = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_n = 0; m_pa = 128; m_ena = 0; m_w = MN + 128 * ST;
      exp_servo = 1'b0; exp_tick = 1'b0;
    end else begin
      m_ph = m_n % F;
      m_n++;
      exp_tick  = (m_ph == 0);
      exp_servo = (m_ena != 0) && (m_ph < m_w);
      if (m_ph == F - 1) begin
        m_pa  = next_pa(int'(pos), m_pa);
        m_ena = int'(ena);
        m_w   = MN + m_pa * ST;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_servo", int'(servo), int'(exp_servo));
      check("cyc_frame_tick", int'(frame_tick), int'(exp_tick));
      check("cyc_pos_applied", int'(pos_applied), m_pa);
    end
  end

  // Align to a frame tick, then count high cycles over one frame, optionally
  // changing inputs after observing frame phase pk_i.
  task automatic measure(input int pk_i, input int pk_pos, input int pk_ena,
                         output int hi, output int pa_tick);
    int waited;
    waited = 0;
    while (frame_tick !== 1'b1 && waited < int'(F) + 5) begin
      @(negedge clk);
      waited++;
    end
    check("tick_found", int'(frame_tick), 1);
    pa_tick = int'(pos_applied);
    hi = 0;
    for (int i = 0; i < int'(F); i++) begin
      if (servo === 1'b1) hi++;
      if (i == pk_i) begin
        pos = 8'(pk_pos);
        ena = pk_ena[0];
      end
      @(negedge clk);
    end
  endtask

  int hi, pa;

  initial begin
    rstn = 1'b0;
    ena  = 1'b1;
`ifdef SERVO_SLEW_EN
    pos  = 8'd128;
`else
    pos  = 8'd0;
`endif
    repeat (3) @(negedge clk);
    check("reset_servo", int'(servo), 0);
    check("reset_tick", int'(frame_tick), 0);
    check("reset_pos_applied", int'(pos_applied), 128);
    chk_en = 1'b1;
    rstn = 1'b1;
    @(negedge clk);
    check("tick_first_cycle", int'(frame_tick), 1);
`ifdef SERVO_SLEW_EN
    measure(F - 2, 140, 1, hi, pa);
`else
    measure(-1, 0, 1, hi, pa);
`endif
    check("silent_first_frame", hi, 0);
    check("first_frame_pa", pa, 128);
    check("period_tick", int'(frame_tick), 1);

`ifdef SERVO_SLEW_EN
    measure(-1, 0, 1, hi, pa);
    check("slew_up1_pa", pa, 132);
    check("slew_up1_width", hi, 446);
    measure(-1, 0, 1, hi, pa);
    check("slew_up2_pa", pa, 136);
    measure(-1, 0, 1, hi, pa);
    check("slew_up3_pa", pa, 140);
    measure(10, 0, 1, hi, pa);
    check("slew_hold_pa", pa, 140);
    check("slew_hold_width", hi, 470);
    measure(-1, 0, 1, hi, pa);
    check("slew_dn1_pa", pa, 136);
    measure(-1, 0, 1, hi, pa);
    check("slew_dn2_pa", pa, 132);
    for (int k = 3; k <= 35; k++) measure(-1, 0, 1, hi, pa);
    check("slew_reach_zero_pa", pa, 0);
    measure(-1, 0, 1, hi, pa);
    check("slew_floor_pa", pa, 0);
    check("slew_floor_width", hi, 50);
`else
    measure(25, 255, 1, hi, pa);
    check("width_pos0_midchange", hi, 50);
    check("pa_pos0", pa, 0);
    check("period_tick2", int'(frame_tick), 1);
    measure(F - 2, 255, 0, hi, pa);
    check("width_pos255", hi, 815);
    check("pa_pos255", pa, 255);
    measure(F - 2, 100, 1, hi, pa);
    check("ena_gated_width", hi, 0);
    check("ena_gated_tick", int'(frame_tick), 1);
    measure(F - 1, 200, 1, hi, pa);
    check("latch_edge_width", hi, 350);
    check("latch_edge_pa", pa, 100);
    measure(-1, 0, 1, hi, pa);
    check("late_change_width", hi, 350);
    check("late_change_pa", pa, 100);
    measure(-1, 0, 1, hi, pa);
    check("late_change_applied_width", hi, 650);
    check("late_change_applied_pa", pa, 200);
`endif

    // Reset in the middle of a pulse
    repeat (10) @(negedge clk);
    check("servo_before_reset", int'(servo), 1);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_servo", int'(servo), 0);
    check("async_reset_tick", int'(frame_tick), 0);
    check("async_reset_pa", int'(pos_applied), 128);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("tick_after_rerelease", int'(frame_tick), 1);
    measure(-1, 0, 1, hi, pa);
    check("silent_after_rerelease", hi, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
